hd44780_read_operation: RTL and testbench
=========================================

# hd44780_read_operation

Bus-read sequencer for the HD44780 character LCD, complementing the write-pulse generator on the same pins. On request it drives RW high, sets RS, and generates one datasheet-compliant E pulse. It samples the 8-bit data bus just before E falls and returns the byte. An optional poll mode repeats busy-flag/address-counter reads until BF clears or a retry limit is reached, so the display controller can replace fixed delays with a real busy check.

## Interface
- `SETUP_CYCLES`, 1: cycles from RW/RS valid to E rise (tAS ≥ 40 ns); must be ≥ 1.
- `E_HIGH_CYCLES`, 3: cycles E is high (≥ 230 ns and > tDDR of 160 ns at 12 MHz); must be ≥ 2.
- `E_LOW_CYCLES`, 3: cycles E is low after the pulse before the next pulse or release; must be ≥ 1. At 12 MHz, `E_HIGH_CYCLES + E_LOW_CYCLES` ≥ 6, giving tcycE ≥ 500 ns.
- `POLL_LIMIT`, 255: maximum reads in one poll request; range 1..255.
- `i_clk` in 1: system clock (12 MHz, 83.3 ns).
- `i_reset` in 1: synchronous reset, active-high.
- `i_ena` in 1: start request, sampled only in IDLE.
- `i_rs` in 1: register select for the read. 0 reads BF and the address counter; 1 reads data RAM.
- `i_poll` in 1: poll mode, latched with `i_ena`. It has an effect only when `i_rs` = 0.
- `i_db` in 8: LCD data bus as seen by the FPGA.
- `o_rw` out 1: LCD RW. High while a read is in progress. The bus tristate control uses it, so the LCD drives the bus when it is high.
- `o_rs` out 1: LCD RS, holding the latched `i_rs`.
- `o_e` out 1: LCD enable.
- `o_data` out 8: last captured byte, held until the next capture.
- `o_valid` out 1: one-cycle pulse when `o_data` holds a result.
- `o_timeout` out 1: one-cycle pulse, coincident with `o_valid`, when a poll ends with BF still 1.
- `o_busy` out 1: high from request acceptance until return to IDLE.

## Operation
- All outputs reset to 0: `o_rw`, `o_rs`, `o_e`, `o_data`, `o_valid`, `o_timeout`, `o_busy`.
- The FSM has four states: IDLE, SETUP, E_HIGH, E_LOW. One down-counter sets the dwell time in each state. An 8-bit attempt counter is used in poll mode.
- IDLE:
  - On `i_ena` = 1, latch `i_rs` into `o_rs` and latch `i_poll & ~i_rs` as the poll flag.
  - Set `o_rw` = 1 and `o_busy` = 1, clear the attempt counter, and go to SETUP.
- SETUP: after `SETUP_CYCLES`, set `o_e` = 1 and go to E_HIGH.
- E_HIGH: after `E_HIGH_CYCLES`, perform the capture:
  - Set `o_e` = 0 and `o_data` <= `i_db`, and increment the attempt counter.
  - Go to E_LOW.
- `o_valid` pulse at capture:
  - Not polling: pulse `o_valid`.
  - Polling with `i_db[7]` = 0: pulse `o_valid`.
  - Polling with attempts reaching `POLL_LIMIT`: pulse `o_valid` together with `o_timeout`.
  - Intermediate poll reads with BF = 1 produce no pulse.
- E_LOW: after `E_LOW_CYCLES`:
  - If polling and the captured BF = 1 and attempts < `POLL_LIMIT`, go to SETUP. `o_rw` and `o_busy` stay high.
  - Otherwise go to IDLE with `o_rw` = 0 and `o_busy` = 0. `o_rs` holds its value.
- `i_ena` while `o_busy` = 1 is ignored; there is no queueing.
- `i_db` is sampled only at the capture edge. It is not otherwise registered and must already be synchronized to `i_clk`.
- Reset mid-operation: on the next edge all outputs return to reset values and the FSM returns to IDLE. No `o_valid` is generated for the aborted read.
- Reset wins over a simultaneous `i_ena`.

## Timing
Defaults, with `i_ena` sampled at edge N:
- N: `o_rw` = 1, `o_rs` valid, `o_busy` = 1.
- N+1: `o_e` rises.
- N+4: `o_e` falls, `o_data` is captured, `o_valid` = 1 during cycle N+4..N+5.
- N+7: `o_rw` = 0, `o_busy` = 0, and a new `i_ena` can be accepted at N+7.

Derived figures:
- E high time = `E_HIGH_CYCLES` × 83.3 ns = 250 ns.
- RW/RS hold after E fall ≥ `E_LOW_CYCLES` cycles.
- Each poll read adds `SETUP_CYCLES + E_HIGH_CYCLES + E_LOW_CYCLES` = 7 cycles.
- `o_valid` always precedes `o_busy` deassertion by `E_LOW_CYCLES` cycles.

## Test plan
- Data read: `i_rs` = 1, `i_db` = 0x41, `i_ena` pulse at N. Required response:
  - `o_rs` = 1 and `o_rw` = 1 from N.
  - `o_e` high N+1..N+4.
  - `o_data` = 0x41 and `o_valid` = 1 for one cycle at N+4; `o_timeout` = 0.
  - `o_busy` low at N+7.
- Poll success: `i_rs` = 0, `i_poll` = 1. `i_db` = 0x85 for the first two reads, then 0x06. Required response:
  - Exactly 3 E pulses.
  - Single `o_valid` with `o_data` = 0x06; `o_timeout` = 0.
  - `o_busy` high for 21 cycles.
- Poll timeout: `POLL_LIMIT` = 4, `i_db` fixed at 0x80. Required response:
  - 4 E pulses.
  - `o_valid` and `o_timeout` both pulse once with `o_data` = 0x80.
  - Then IDLE with `o_rw` = 0.
- Poll ignored for RS = 1: `i_rs` = 1, `i_poll` = 1, `i_db` = 0x80. Required response: one E pulse, `o_valid` with 0x80, `o_timeout` = 0.
- Busy lockout: second `i_ena` at N+2 during a read. Required response: no second E pulse and no second `o_valid`; `o_busy` falls at N+7.
- Reset mid-pulse: `i_reset` at N+2. Required response:
  - At N+3 all outputs are 0 and no `o_valid` occurs.
  - A fresh `i_ena` at N+5 completes a normal read with correct timing.

Source files
------------

// File: rtl/hd44780_read_operation.sv
// ----------------------------------------------------------------------------
// hd44780_read_operation
//
// Bus-read sequencer for an HD44780 character LCD. On a start request it
// drives RW high, presents RS, produces one E pulse and captures the data
// bus on the cycle E falls. In poll mode (RS = 0 only) it keeps re-reading
// the busy-flag / address-counter register until BF (bit 7) clears or
// POLL_LIMIT reads have been made.
//
// Parameters
//   SETUP_CYCLES  : cycles from RW/RS valid to E rise (>= 1)
//   E_HIGH_CYCLES : cycles E is high (>= 2)
//   E_LOW_CYCLES  : cycles E is low after each pulse (>= 1)
//   POLL_LIMIT    : maximum reads per poll request (1..255)
//
// Ports
//   i_clk     : system clock
//   i_reset   : synchronous reset, active-high
//   i_ena     : start request, only honoured while idle
//   i_rs      : register select for the read (0 = BF/AC, 1 = data RAM)
//   i_poll    : poll mode request, latched with i_ena, only used when i_rs = 0
//   i_db      : LCD data bus, already synchronous to i_clk
//   o_rw      : LCD RW, high while a read is in progress
//   o_rs      : LCD RS, holds the latched i_rs
//   o_e       : LCD enable
//   o_data    : last captured byte
//   o_valid   : one-cycle pulse when o_data holds a result
//   o_timeout : one-cycle pulse with o_valid when a poll ends with BF = 1
//   o_busy    : high from request acceptance until return to idle
// ----------------------------------------------------------------------------
module hd44780_read_operation #(
    parameter int SETUP_CYCLES  = 1,
    parameter int E_HIGH_CYCLES = 3,
    parameter int E_LOW_CYCLES  = 3,
    parameter int POLL_LIMIT    = 255
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ena,
    input  logic       i_rs,
    input  logic       i_poll,
    input  logic [7:0] i_db,
    output logic       o_rw,
    output logic       o_rs,
    output logic       o_e,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_timeout,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        E_HIGH,
        E_LOW
    } state_t;

    // Dwell counters are loaded with N-1 so a state lasts exactly N cycles.
    localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] E_HIGH_LOAD = 8'(E_HIGH_CYCLES - 1);
    localparam logic [7:0] E_LOW_LOAD  = 8'(E_LOW_CYCLES - 1);
    localparam logic [7:0] LIMIT       = 8'(POLL_LIMIT);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  attempts_q;
    logic [7:0]  attempts_inc;
    logic        poll_q;
    logic        rw_q;
    logic        rs_q;
    logic        e_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        timeout_q;
    logic        busy_q;

    assign attempts_inc = attempts_q + 8'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            attempts_q <= '0;
            poll_q     <= 1'b0;
            rw_q       <= 1'b0;
            rs_q       <= 1'b0;
            e_q        <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_ena) begin
                        rs_q       <= i_rs;
                        // Polling only makes sense on the BF/AC register.
                        poll_q     <= i_poll & ~i_rs;
                        rw_q       <= 1'b1;
                        busy_q     <= 1'b1;
                        attempts_q <= '0;
                        cnt_q      <= SETUP_LOAD;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == 8'd0) begin
                        e_q     <= 1'b1;
                        cnt_q   <= E_HIGH_LOAD;
                        state_q <= E_HIGH;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                E_HIGH: begin
                    if (cnt_q == 8'd0) begin
                        // Capture on the same edge that drops E, so the bus
                        // is sampled while the LCD is still driving it.
                        e_q        <= 1'b0;
                        data_q     <= i_db;
                        attempts_q <= attempts_inc;
                        cnt_q      <= E_LOW_LOAD;
                        state_q    <= E_LOW;
                        if (!poll_q || !i_db[7]) begin
                            valid_q <= 1'b1;
                        end else if (attempts_inc >= LIMIT) begin
                            valid_q   <= 1'b1;
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                E_LOW: begin
                    if (cnt_q == 8'd0) begin
                        if (poll_q && data_q[7] && (attempts_q < LIMIT)) begin
                            cnt_q   <= SETUP_LOAD;
                            state_q <= SETUP;
                        end else begin
                            rw_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_rw      = rw_q;
    assign o_rs      = rs_q;
    assign o_e       = e_q;
    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_hd44780_read_operation.sv
// ----------------------------------------------------------------------------
// tb_hd44780_read_operation
//
// Directed bench for hd44780_read_operation, built with POLL_LIMIT = 4 so the
// poll-timeout case stays short. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_hd44780_read_operation;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       rs;
    logic       poll;
    logic [7:0] db;
    logic       rw_o;
    logic       rs_o;
    logic       e_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       timeout_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;

    hd44780_read_operation #(
        .SETUP_CYCLES (1),
        .E_HIGH_CYCLES(3),
        .E_LOW_CYCLES (3),
        .POLL_LIMIT   (4)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_ena    (ena),
        .i_rs     (rs),
        .i_poll   (poll),
        .i_db     (db),
        .o_rw     (rw_o),
        .o_rs     (rs_o),
        .o_e      (e_o),
        .o_data   (data_o),
        .o_valid  (valid_o),
        .o_timeout(timeout_o),
        .o_busy   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single data-RAM read with cycle-exact checks; edge N is the edge that
    // samples i_ena.
    task automatic data_read(input string pfx, input logic [7:0] val);
        rs   = 1'b1;
        poll = 1'b0;
        db   = val;
        ena  = 1'b1;
        tick();                                    // N
        ena  = 1'b0;
        check({pfx, "_rw_N"},   rw_o,   1);
        check({pfx, "_rs_N"},   rs_o,   1);
        check({pfx, "_busy_N"}, busy_o, 1);
        check({pfx, "_e_N"},    e_o,    0);
        tick();                                    // N+1
        check({pfx, "_e_N1"},   e_o,    1);
        tick();
        tick();                                    // N+3
        check({pfx, "_e_N3"},   e_o,    1);
        check({pfx, "_vld_N3"}, valid_o, 0);
        tick();                                    // N+4
        check({pfx, "_e_N4"},   e_o,    0);
        check({pfx, "_vld_N4"}, valid_o, 1);
        check({pfx, "_dat_N4"}, data_o, val);
        check({pfx, "_to_N4"},  timeout_o, 0);
        tick();                                    // N+5
        check({pfx, "_vld_N5"}, valid_o, 0);
        check({pfx, "_rw_N5"},  rw_o,   1);
        tick();                                    // N+6
        check({pfx, "_busy_N6"}, busy_o, 1);
        tick();                                    // N+7
        check({pfx, "_busy_N7"}, busy_o, 0);
        check({pfx, "_rw_N7"},   rw_o,   0);
        check({pfx, "_rs_hold"}, rs_o,   1);
    endtask

    // Start one request and follow it until o_busy drops, counting E pulses,
    // o_valid / o_timeout pulses and busy cycles. db switches to db_after once
    // switch_after E falls have been seen; a second i_ena is raised so that
    // edge N+again_at samples it (again_at < 0 disables that).
    task automatic run_op(input logic rs_v, input logic poll_v,
                          input logic [7:0] db0, input logic [7:0] db_after,
                          input int switch_after, input int again_at,
                          output int pulses, output int valids, output int touts,
                          output int busy_cyc, output logic [7:0] vdata,
                          output logic done);
        logic prev_e;
        int   falls;
        pulses   = 0;
        valids   = 0;
        touts    = 0;
        busy_cyc = 0;
        vdata    = 8'h00;
        done     = 1'b0;
        falls    = 0;
        prev_e   = 1'b0;
        rs   = rs_v;
        poll = poll_v;
        db   = db0;
        ena  = 1'b1;
        tick();                                    // N
        ena  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!busy_o) begin
                done = 1'b1;
                break;
            end
            busy_cyc++;
            if (e_o && !prev_e) pulses++;
            if (!e_o && prev_e) begin
                falls++;
                if (falls == switch_after) db = db_after;
            end
            if (valid_o) begin
                valids++;
                vdata = data_o;
            end
            if (timeout_o) touts++;
            prev_e = e_o;
            ena = (again_at >= 0 && k == again_at - 1);
            tick();
        end
        ena = 1'b0;
    endtask

    int         pulses;
    int         valids;
    int         touts;
    int         busy_cyc;
    logic [7:0] vdata;
    logic       done;

    initial begin
        rst  = 1'b1;
        ena  = 1'b0;
        rs   = 1'b0;
        poll = 1'b0;
        db   = 8'h00;
        tick();
        tick();
        check("rst_rw",      rw_o,      0);
        check("rst_rs",      rs_o,      0);
        check("rst_e",       e_o,       0);
        check("rst_data",    data_o,    0);
        check("rst_valid",   valid_o,   0);
        check("rst_timeout", timeout_o, 0);
        check("rst_busy",    busy_o,    0);

        // Reset wins over a simultaneous request.
        ena = 1'b1;
        tick();
        ena = 1'b0;
        check("rst_vs_ena_busy", busy_o, 0);
        rst = 1'b0;
        tick();

        data_read("rd41", 8'h41);
        tick();

        // Poll success: BF set on first two reads, clear on the third.
        run_op(1'b0, 1'b1, 8'h85, 8'h06, 2, -1, pulses, valids, touts, busy_cyc, vdata, done);
        check("ps_done",   done,     1);
        check("ps_pulses", pulses,   3);
        check("ps_valids", valids,   1);
        check("ps_data",   vdata,    8'h06);
        check("ps_touts",  touts,    0);
        check("ps_busy",   busy_cyc, 21);
        tick();

        // Poll timeout with POLL_LIMIT = 4.
        run_op(1'b0, 1'b1, 8'h80, 8'h80, 0, -1, pulses, valids, touts, busy_cyc, vdata, done);
        check("pt_done",   done,     1);
        check("pt_pulses", pulses,   4);
        check("pt_valids", valids,   1);
        check("pt_touts",  touts,    1);
        check("pt_data",   vdata,    8'h80);
        check("pt_busy",   busy_cyc, 28);
        check("pt_rw",     rw_o,     0);
        tick();

        // Poll request ignored when reading data RAM.
        run_op(1'b1, 1'b1, 8'h80, 8'h80, 0, -1, pulses, valids, touts, busy_cyc, vdata, done);
        check("pr_done",   done,   1);
        check("pr_pulses", pulses, 1);
        check("pr_valids", valids, 1);
        check("pr_data",   vdata,  8'h80);
        check("pr_touts",  touts,  0);
        tick();

        // Busy lockout: second request sampled at N+2.
        run_op(1'b1, 1'b0, 8'h5A, 8'h5A, 0, 2, pulses, valids, touts, busy_cyc, vdata, done);
        check("bl_done",   done,     1);
        check("bl_pulses", pulses,   1);
        check("bl_valids", valids,   1);
        check("bl_busy",   busy_cyc, 7);
        tick();
        tick();
        check("bl_idle_busy", busy_o, 0);
        check("bl_idle_e",    e_o,    0);

        // Reset during the E pulse, sampled at N+3.
        rs  = 1'b1;
        db  = 8'h77;
        ena = 1'b1;
        tick();                                    // N
        ena = 1'b0;
        tick();                                    // N+1
        check("rm_e_N1", e_o, 1);
        tick();                                    // N+2
        rst = 1'b1;
        tick();                                    // N+3
        rst = 1'b0;
        check("rm_rw",    rw_o,      0);
        check("rm_rs",    rs_o,      0);
        check("rm_e",     e_o,       0);
        check("rm_data",  data_o,    0);
        check("rm_valid", valid_o,   0);
        check("rm_to",    timeout_o, 0);
        check("rm_busy",  busy_o,    0);
        tick();                                    // N+4
        check("rm_valid_N4", valid_o, 0);
        data_read("rdrm", 8'h3C);                  // request sampled at N+5

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
